// File: rtl/issue_select.sv
// issue_select: dual-issue selection stage in front of the execute pipe.
//
// Scans eight issue-queue entries, picks up to two ready ones per cycle
// (lowest index first), pops them from the queue and registers them as
// the issued pair. A 32-entry busy scoreboard tracks in-flight destination
// registers. Register 0 is never busy.
//
// Entry layout: [4:0] rs, [9:5] rt, [14:10] rd, [15] rd_wr, [16] valid,
// and the upper bits are opaque payload.
//
// Ports
//   clk, rst_n            clock, async active-low reset
//   flush                 clears issued slots and the scoreboard, no pops
//   stall                 execute cannot accept: hold issued slots, no pops
//   data0..data7          issue-queue entries (all-zero when invalid)
//   pop0/pop1             combinational pop strobes to the issue queue
//   pop_key0/pop_key1     popped slot index (0 when not popping)
//   wb0_en/wb0_rd, wb1_*  writeback ports, clear busy bits
//   iss0_vld/iss0_data    registered issued entry, slot 0
//   iss1_vld/iss1_data    registered issued entry, slot 1
//
// Build option: WB_BYPASS_EN makes a source ready in the same cycle its tag
// appears on an enabled writeback port. Without it, wakeup waits for the
// registered busy bit to clear, one cycle later.

`ifndef IQ_ENTRY_SIZE
`define IQ_ENTRY_SIZE 32
`endif
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 3
`endif

module issue_select (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            flush,
  input  logic                            stall,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data0,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data1,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data2,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data3,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data4,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data5,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data6,
  input  logic [`IQ_ENTRY_SIZE-1:0]       data7,
  output logic                            pop0,
  output logic                            pop1,
  output logic [`NUM_IQ_ENTRIES_LOG2-1:0] pop_key0,
  output logic [`NUM_IQ_ENTRIES_LOG2-1:0] pop_key1,
  input  logic                            wb0_en,
  input  logic                            wb1_en,
  input  logic [4:0]                      wb0_rd,
  input  logic [4:0]                      wb1_rd,
  output logic                            iss0_vld,
  output logic                            iss1_vld,
  output logic [`IQ_ENTRY_SIZE-1:0]       iss0_data,
  output logic [`IQ_ENTRY_SIZE-1:0]       iss1_data
);

  localparam int W  = `IQ_ENTRY_SIZE;
  localparam int KW = `NUM_IQ_ENTRIES_LOG2;
  localparam int N  = 8;

  logic [W-1:0]  entry [N];
  logic [31:0]   busy;
  logic [31:0]   wb_clr;
  logic [31:0]   busy_src;
  logic [31:0]   busy_set;
  logic [31:0]   busy_nx;
  logic [N-1:0]  ready;
  logic          found0;
  logic          found1;
  logic [KW-1:0] sel0;
  logic [KW-1:0] sel1;
  logic [W-1:0]  ent0;
  logic [W-1:0]  ent1;
  logic [4:0]    rd0;
  logic          blk0;
  logic          go;

  assign entry[0] = data0;
  assign entry[1] = data1;
  assign entry[2] = data2;
  assign entry[3] = data3;
  assign entry[4] = data4;
  assign entry[5] = data5;
  assign entry[6] = data6;
  assign entry[7] = data7;

  always_comb begin
    wb_clr = '0;
    if (wb0_en) wb_clr[wb0_rd] = 1'b1;
    if (wb1_en) wb_clr[wb1_rd] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  assign busy_src = busy & ~wb_clr;
`else
  assign busy_src = busy;
`endif

  always_comb begin
    ready = '0;
    for (int i = 0; i < N; i++) begin
      ready[i] = entry[i][16] && !busy_src[entry[i][4:0]] && !busy_src[entry[i][9:5]];
    end
  end

  // Descending scan so the last hit is the lowest index.
  always_comb begin
    found0 = 1'b0;
    sel0   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (ready[i]) begin
        found0 = 1'b1;
        sel0   = KW'(i);
      end
    end
  end

  assign ent0 = entry[sel0];
  assign rd0  = ent0[14:10];
  // Slot 1 must not consume a result slot 0 is about to produce.
  assign blk0 = found0 && ent0[15] && (rd0 != 5'd0);

  always_comb begin
    found1 = 1'b0;
    sel1   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (found0 && ready[i] && (i > int'(sel0)) &&
          !(blk0 && ((entry[i][4:0] == rd0) || (entry[i][9:5] == rd0)))) begin
        found1 = 1'b1;
        sel1   = KW'(i);
      end
    end
  end

  assign ent1 = entry[sel1];

  // rst_n gates the strobes so the queue sees no pops while reset is held.
  assign go       = rst_n && !stall && !flush;
  assign pop0     = found0 && go;
  assign pop1     = found1 && pop0;
  assign pop_key0 = pop0 ? sel0 : '0;
  assign pop_key1 = pop1 ? sel1 : '0;

  always_comb begin
    busy_set = '0;
    if (pop0 && ent0[15]) busy_set[ent0[14:10]] = 1'b1;
    if (pop1 && ent1[15]) busy_set[ent1[14:10]] = 1'b1;
  end

  // Set wins over a same-edge writeback clear of the same tag.
  assign busy_nx = ((busy & ~wb_clr) | busy_set) & ~32'h1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy      <= '0;
      iss0_vld  <= 1'b0;
      iss1_vld  <= 1'b0;
      iss0_data <= '0;
      iss1_data <= '0;
    end else if (flush) begin
      busy     <= '0;
      iss0_vld <= 1'b0;
      iss1_vld <= 1'b0;
    end else begin
      busy <= busy_nx;
      if (!stall) begin
        iss0_vld <= pop0;
        iss1_vld <= pop1;
        if (pop0) iss0_data <= ent0;
        if (pop1) iss1_data <= ent1;
      end
    end
  end

endmodule

// File: tb/tb_issue_select.sv
`ifndef IQ_ENTRY_SIZE
`define IQ_ENTRY_SIZE 32
`endif
`ifndef NUM_IQ_ENTRIES_LOG2
`define NUM_IQ_ENTRIES_LOG2 3
`endif

module tb_issue_select;

  localparam int W  = `IQ_ENTRY_SIZE;
  localparam int KW = `NUM_IQ_ENTRIES_LOG2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          flush = 1'b0;
  logic          stall = 1'b0;
  logic [W-1:0]  data0 = '0, data1 = '0, data2 = '0, data3 = '0;
  logic [W-1:0]  data4 = '0, data5 = '0, data6 = '0, data7 = '0;
  logic          pop0, pop1;
  logic [KW-1:0] pop_key0, pop_key1;
  logic          wb0_en = 1'b0, wb1_en = 1'b0;
  logic [4:0]    wb0_rd = '0, wb1_rd = '0;
  logic          iss0_vld, iss1_vld;
  logic [W-1:0]  iss0_data, iss1_data;

  int checks = 0;
  int failures = 0;

  issue_select dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
    .data0(data0), .data1(data1), .data2(data2), .data3(data3),
    .data4(data4), .data5(data5), .data6(data6), .data7(data7),
    .pop0(pop0), .pop1(pop1), .pop_key0(pop_key0), .pop_key1(pop_key1),
    .wb0_en(wb0_en), .wb1_en(wb1_en), .wb0_rd(wb0_rd), .wb1_rd(wb1_rd),
    .iss0_vld(iss0_vld), .iss1_vld(iss1_vld),
    .iss0_data(iss0_data), .iss1_data(iss1_data)
  );

  always #5 clk = ~clk;

  initial begin
    #90000;
    $display("FAIL timeout: bench did not finish, got=running exp=finished");
    $fatal(1, "timeout");
  end

  function automatic logic [W-1:0] mk(input logic [4:0] rs, input logic [4:0] rt,
                                      input logic [4:0] rd, input logic wr,
                                      input logic [14:0] tag);
    logic [W-1:0] e;
    e = '0;
    e[4:0]   = rs;
    e[9:5]   = rt;
    e[14:10] = rd;
    e[15]    = wr;
    e[16]    = 1'b1;
    e[31:17] = tag;
    return e;
  endfunction

  task automatic clear_inputs();
    data0 = '0; data1 = '0; data2 = '0; data3 = '0;
    data4 = '0; data5 = '0; data6 = '0; data7 = '0;
    flush = 1'b0; stall = 1'b0;
    wb0_en = 1'b0; wb1_en = 1'b0; wb0_rd = '0; wb1_rd = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    data2 = mk(5'd1, 5'd2, 5'd3, 1'b1, 15'h0a0a);
    #3;
    checks++; if (pop0 !== 1'b0) begin failures++; $display("FAIL reset_pop0 got=%0b exp=0", pop0); end
    checks++; if (pop_key0 !== '0) begin failures++; $display("FAIL reset_key0 got=%0d exp=0", pop_key0); end
    checks++; if (iss0_vld !== 1'b0 || iss1_vld !== 1'b0) begin failures++; $display("FAIL reset_vld got=%0b%0b exp=00", iss0_vld, iss1_vld); end
    checks++; if (iss0_data !== '0 || iss1_data !== '0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0/0", iss0_data, iss1_data); end
    tick();
    checks++; if (iss0_vld !== 1'b0) begin failures++; $display("FAIL reset_hold_vld got=%0b exp=0", iss0_vld); end
    rst_n = 1'b1;
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd2) begin failures++; $display("FAIL reset_release_pop got=%0b/%0d exp=1/2", pop0, pop_key0); end
  endtask

  task automatic test_dual_issue();
    logic [W-1:0] e2, e5;
    do_reset();
    e2 = mk(5'd1, 5'd2, 5'd10, 1'b1, 15'h1111);
    e5 = mk(5'd3, 5'd4, 5'd11, 1'b1, 15'h5555);
    data2 = e2; data5 = e5;
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd2) begin failures++; $display("FAIL dual_pop0 got=%0b/%0d exp=1/2", pop0, pop_key0); end
    checks++; if (pop1 !== 1'b1 || pop_key1 !== 3'd5) begin failures++; $display("FAIL dual_pop1 got=%0b/%0d exp=1/5", pop1, pop_key1); end
    tick();
    data2 = '0; data5 = '0;
    checks++; if (iss0_vld !== 1'b1 || iss0_data !== e2) begin failures++; $display("FAIL dual_iss0 got=%0b/%h exp=1/%h", iss0_vld, iss0_data, e2); end
    checks++; if (iss1_vld !== 1'b1 || iss1_data !== e5) begin failures++; $display("FAIL dual_iss1 got=%0b/%h exp=1/%h", iss1_vld, iss1_data, e5); end
    settle();
    checks++; if (pop0 !== 1'b0 || pop1 !== 1'b0 || pop_key0 !== '0 || pop_key1 !== '0) begin failures++; $display("FAIL dual_idle_pops got=%0b%0b/%0d/%0d exp=00/0/0", pop0, pop1, pop_key0, pop_key1); end
    tick();
    checks++; if (iss0_vld !== 1'b0 || iss1_vld !== 1'b0) begin failures++; $display("FAIL dual_drain_vld got=%0b%0b exp=00", iss0_vld, iss1_vld); end
  endtask

  task automatic test_slot1_select();
    do_reset();
    data0 = mk(5'd3, 5'd4, 5'd6, 1'b1, 15'h0001);
    data1 = mk(5'd6, 5'd5, 5'd0, 1'b0, 15'h0002);
    data4 = mk(5'd2, 5'd3, 5'd11, 1'b1, 15'h0003);
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd0) begin failures++; $display("FAIL skip_pop0 got=%0b/%0d exp=1/0", pop0, pop_key0); end
    checks++; if (pop1 !== 1'b1 || pop_key1 !== 3'd4) begin failures++; $display("FAIL skip_pop1 got=%0b/%0d exp=1/4", pop1, pop_key1); end
    data1 = mk(5'd5, 5'd6, 5'd0, 1'b0, 15'h0002);
    data4 = '0;
    settle();
    checks++; if (pop1 !== 1'b0 || pop_key1 !== '0) begin failures++; $display("FAIL rt_conflict_pop1 got=%0b/%0d exp=0/0", pop1, pop_key1); end
    data0 = mk(5'd1, 5'd1, 5'd0, 1'b1, 15'h0004);
    data1 = mk(5'd0, 5'd0, 5'd7, 1'b0, 15'h0005);
    settle();
    checks++; if (pop1 !== 1'b1 || pop_key1 !== 3'd1) begin failures++; $display("FAIL rd0_noblock_pop1 got=%0b/%0d exp=1/1", pop1, pop_key1); end
    data0 = mk(5'd1, 5'd2, 5'd6, 1'b0, 15'h0006);
    data1 = mk(5'd6, 5'd6, 5'd7, 1'b0, 15'h0007);
    settle();
    checks++; if (pop1 !== 1'b1 || pop_key1 !== 3'd1) begin failures++; $display("FAIL nowr_noblock_pop1 got=%0b/%0d exp=1/1", pop1, pop_key1); end
  endtask

  task automatic test_dependency();
    logic [W-1:0] e1, e3;
    do_reset();
    e1 = mk(5'd1, 5'd2, 5'd7, 1'b1, 15'h00a1);
    e3 = mk(5'd7, 5'd0, 5'd0, 1'b0, 15'h00a3);
    data1 = e1; data3 = e3;
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd1) begin failures++; $display("FAIL dep_pop0 got=%0b/%0d exp=1/1", pop0, pop_key0); end
    checks++; if (pop1 !== 1'b0 || pop_key1 !== '0) begin failures++; $display("FAIL dep_pop1 got=%0b/%0d exp=0/0", pop1, pop_key1); end
    tick();
    data1 = '0;
    checks++; if (iss0_vld !== 1'b1 || iss0_data !== e1 || iss1_vld !== 1'b0) begin failures++; $display("FAIL dep_iss got=%0b/%h/%0b exp=1/%h/0", iss0_vld, iss0_data, iss1_vld, e1); end
    settle();
    checks++; if (pop0 !== 1'b0) begin failures++; $display("FAIL dep_blocked got=%0b exp=0", pop0); end
    tick();
    checks++; if (pop0 !== 1'b0 || iss0_vld !== 1'b0) begin failures++; $display("FAIL dep_still_blocked got=%0b/%0b exp=0/0", pop0, iss0_vld); end
    wb0_en = 1'b1; wb0_rd = 5'd7;
    settle();
`ifdef WB_BYPASS_EN
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd3) begin failures++; $display("FAIL dep_wakeup got=%0b/%0d exp=1/3", pop0, pop_key0); end
    tick();
    wb0_en = 1'b0; data3 = '0;
`else
    checks++; if (pop0 !== 1'b0) begin failures++; $display("FAIL dep_wb_cycle got=%0b exp=0", pop0); end
    tick();
    wb0_en = 1'b0;
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd3) begin failures++; $display("FAIL dep_wakeup got=%0b/%0d exp=1/3", pop0, pop_key0); end
    tick();
    data3 = '0;
`endif
    checks++; if (iss0_vld !== 1'b1 || iss0_data !== e3) begin failures++; $display("FAIL dep_iss3 got=%0b/%h exp=1/%h", iss0_vld, iss0_data, e3); end
  endtask

  task automatic test_stall();
    logic [W-1:0] e0, eb, e6;
    do_reset();
    e0 = mk(5'd1, 5'd2, 5'd3, 1'b0, 15'h0b00);
    eb = mk(5'd4, 5'd5, 5'd6, 1'b0, 15'h0b01);
    e6 = mk(5'd7, 5'd8, 5'd9, 1'b0, 15'h0b06);
    data0 = e0;
    settle();
    tick();
    data0 = eb; data6 = e6; stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      checks++; if (pop0 !== 1'b0 || pop1 !== 1'b0) begin failures++; $display("FAIL stall_pops cyc=%0d got=%0b%0b exp=00", c, pop0, pop1); end
      tick();
      checks++; if (iss0_vld !== 1'b1 || iss0_data !== e0 || iss1_vld !== 1'b0) begin failures++; $display("FAIL stall_hold cyc=%0d got=%0b/%h/%0b exp=1/%h/0", c, iss0_vld, iss0_data, iss1_vld, e0); end
    end
    stall = 1'b0;
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd0 || pop1 !== 1'b1 || pop_key1 !== 3'd6) begin failures++; $display("FAIL stall_resume got=%0b/%0d %0b/%0d exp=1/0 1/6", pop0, pop_key0, pop1, pop_key1); end
    tick();
    data0 = '0; data6 = '0;
    checks++; if (iss0_data !== eb || iss1_data !== e6 || iss1_vld !== 1'b1) begin failures++; $display("FAIL stall_resume_iss got=%h/%h/%0b exp=%h/%h/1", iss0_data, iss1_data, iss1_vld, eb, e6); end
  endtask

  task automatic test_wb_collision();
    do_reset();
    data0 = mk(5'd1, 5'd2, 5'd9, 1'b1, 15'h0c09);
    wb1_en = 1'b1; wb1_rd = 5'd9;
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd0) begin failures++; $display("FAIL coll_pop got=%0b/%0d exp=1/0", pop0, pop_key0); end
    tick();
    data0 = '0; wb1_en = 1'b0;
    data2 = mk(5'd9, 5'd3, 5'd12, 1'b0, 15'h0c02);
    settle();
    checks++; if (pop0 !== 1'b0) begin failures++; $display("FAIL coll_dep_blocked got=%0b exp=0", pop0); end
    tick();
    checks++; if (pop0 !== 1'b0) begin failures++; $display("FAIL coll_dep_blocked2 got=%0b exp=0", pop0); end
  endtask

  task automatic test_flush();
    do_reset();
    data0 = mk(5'd1, 5'd2, 5'd4, 1'b1, 15'h0d04);
    settle();
    tick();
    data0 = '0;
    checks++; if (iss0_vld !== 1'b1) begin failures++; $display("FAIL flush_pre_vld got=%0b exp=1", iss0_vld); end
    data1 = mk(5'd2, 5'd3, 5'd0, 1'b0, 15'h0d01);
    data3 = mk(5'd4, 5'd1, 5'd0, 1'b0, 15'h0d03);
    flush = 1'b1; stall = 1'b1;
    settle();
    checks++; if (pop0 !== 1'b0 || pop1 !== 1'b0) begin failures++; $display("FAIL flush_pops got=%0b%0b exp=00", pop0, pop1); end
    tick();
    checks++; if (iss0_vld !== 1'b0 || iss1_vld !== 1'b0) begin failures++; $display("FAIL flush_vld got=%0b%0b exp=00", iss0_vld, iss1_vld); end
    flush = 1'b0; stall = 1'b0;
    settle();
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd1 || pop1 !== 1'b1 || pop_key1 !== 3'd3) begin failures++; $display("FAIL flush_busy_cleared got=%0b/%0d %0b/%0d exp=1/1 1/3", pop0, pop_key0, pop1, pop_key1); end
  endtask

  task automatic test_async_reset();
    do_reset();
    data0 = mk(5'd1, 5'd2, 5'd8, 1'b1, 15'h0e08);
    settle();
    tick();
    data0 = '0;
    checks++; if (iss0_vld !== 1'b1) begin failures++; $display("FAIL arst_pre_vld got=%0b exp=1", iss0_vld); end
    data2 = mk(5'd8, 5'd8, 5'd0, 1'b0, 15'h0e02);
    settle();
    checks++; if (pop0 !== 1'b0) begin failures++; $display("FAIL arst_pre_blocked got=%0b exp=0", pop0); end
    rst_n = 1'b0;
    #1;
    checks++; if (iss0_vld !== 1'b0 || iss0_data !== '0 || pop0 !== 1'b0) begin failures++; $display("FAIL arst_immediate got=%0b/%h/%0b exp=0/0/0", iss0_vld, iss0_data, pop0); end
    rst_n = 1'b1;
    #1;
    checks++; if (pop0 !== 1'b1 || pop_key0 !== 3'd2) begin failures++; $display("FAIL arst_scoreboard got=%0b/%0d exp=1/2", pop0, pop_key0); end
  endtask

  initial begin
    test_reset();
    test_dual_issue();
    test_slot1_select();
    test_dependency();
    test_stall();
    test_wb_collision();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
